// File: rtl/risc_v_pkg.sv
// Shared definitions for the RISC-V core: fetch FSM states, instruction
// geometry and the base opcodes used by the control unit.
package risc_v_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    WAIT  = 2'b01,
    HOLD  = 2'b10
  } fetch_state_t;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

endpackage

// File: rtl/instruction_fetch_pc_reg.sv
// Program counter register: load on redirect, step by one instruction,
// and keep the two low bits at zero so every address is word aligned.
module pc_reg
  import risc_v_pkg::*;
#(
  parameter int                    WORDSIZE = 64,
  parameter logic [WORDSIZE-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_en,
  input  logic [WORDSIZE-1:0] load_pc,
  input  logic                inc_en,
  output logic [WORDSIZE-1:0] pc
);

  localparam logic [WORDSIZE-1:0] ALIGN_MASK = ~WORDSIZE'(3);
  localparam logic [WORDSIZE-1:0] STEP       = WORDSIZE'(INSTR_BYTES);

  // Redirect load wins over increment; increment wraps modulo 2^WORDSIZE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC & ALIGN_MASK;
    end else if (load_en) begin
      pc <= load_pc & ALIGN_MASK;
    end else if (inc_en) begin
      pc <= pc + STEP;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues one instruction-memory request at a time, presents the
// returned word with its PC to decode, and flushes on redirects.
module instruction_fetch
  import risc_v_pkg::*;
#(
  parameter int                  WORDSIZE         = 64,
  parameter int                  INSTRUCTION_SIZE = 32,
  parameter logic [WORDSIZE-1:0] RESET_PC         = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        redirect_en,
  input  logic [WORDSIZE-1:0]         redirect_pc,
  output logic                        imem_req,
  output logic [WORDSIZE-1:0]         imem_addr,
  input  logic                        imem_gnt,
  input  logic                        imem_rvalid,
  input  logic [INSTRUCTION_SIZE-1:0] imem_rdata,
  output logic [INSTRUCTION_SIZE-1:0] instruction,
  output logic [WORDSIZE-1:0]         if_pc,
  output logic                        if_valid,
  input  logic                        if_ready
);

  fetch_state_t                state, state_next;
  logic                        kill, kill_next;
  logic                        hold_valid, hold_valid_next;
  logic [INSTRUCTION_SIZE-1:0] instruction_next;
  logic [WORDSIZE-1:0]         if_pc_next;
  logic                        pc_load, pc_inc;
  logic [WORDSIZE-1:0]         pc;

  pc_reg #(
    .WORDSIZE (WORDSIZE),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_en (pc_load),
    .load_pc (redirect_pc),
    .inc_en  (pc_inc),
    .pc      (pc)
  );

  assign imem_req  = (state == FETCH) & ~redirect_en;
  assign imem_addr = pc;
  assign if_valid  = hold_valid & ~redirect_en;

  // State and presentation registers; the PC itself lives in pc_reg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      kill        <= 1'b0;
      instruction <= '0;
      if_pc       <= '0;
      hold_valid  <= 1'b0;
    end else begin
      state       <= state_next;
      kill        <= kill_next;
      instruction <= instruction_next;
      if_pc       <= if_pc_next;
      hold_valid  <= hold_valid_next;
    end
  end

  // Next-state logic: request, wait for (or flush) the response, then hold for decode.
  always_comb begin
    state_next       = state;
    kill_next        = kill;
    hold_valid_next  = hold_valid;
    instruction_next = instruction;
    if_pc_next       = if_pc;
    pc_load          = 1'b0;
    pc_inc           = 1'b0;
    case (state)
      FETCH: begin
        if (redirect_en) begin
          pc_load = 1'b1;
        end else if (imem_gnt) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (kill || redirect_en) begin
            kill_next  = 1'b0;
            pc_load    = redirect_en;
            state_next = FETCH;
          end else begin
            instruction_next = imem_rdata;
            if_pc_next       = pc;
            hold_valid_next  = 1'b1;
            pc_inc           = 1'b1;
            state_next       = HOLD;
          end
        end else if (redirect_en) begin
          pc_load   = 1'b1;
          kill_next = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_en) begin
          hold_valid_next = 1'b0;
          pc_load         = 1'b1;
          state_next      = FETCH;
        end else if (if_valid && if_ready) begin
          hold_valid_next = 1'b0;
          state_next      = FETCH;
        end
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized memory timing, backpressure and redirects against a transaction model.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_ready;

  logic        imem_req,    w_imem_req;
  logic [63:0] imem_addr,   w_imem_addr;
  logic [31:0] instruction, w_instruction;
  logic [63:0] if_pc,       w_if_pc;
  logic        if_valid,    w_if_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the fetch stage in transaction terms
  logic [63:0] m_pc;
  logic        m_busy, m_flush, m_present;
  logic [31:0] m_instr;
  logic [63:0] m_ipc;
  logic        exp_req, exp_valid;

  // Memory side of the bench
  logic        mem_pending;
  int unsigned mem_delay;
  logic [31:0] mem_data;

  instruction_fetch #(
    .WORDSIZE (64), .INSTRUCTION_SIZE (32), .RESET_PC (64'h0)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .redirect_en (redirect_en), .redirect_pc (redirect_pc),
    .imem_req (imem_req), .imem_addr (imem_addr),
    .imem_gnt (imem_gnt), .imem_rvalid (imem_rvalid), .imem_rdata (imem_rdata),
    .instruction (instruction), .if_pc (if_pc), .if_valid (if_valid),
    .if_ready (if_ready)
  );

  instruction_fetch #(
    .WORDSIZE (64), .INSTRUCTION_SIZE (32), .RESET_PC (64'hFFFF_FFFF_FFFF_FFFC)
  ) dut_wrap (
    .clk (clk), .rst_n (rst_n),
    .redirect_en (redirect_en), .redirect_pc (redirect_pc),
    .imem_req (w_imem_req), .imem_addr (w_imem_addr),
    .imem_gnt (imem_gnt), .imem_rvalid (imem_rvalid), .imem_rdata (imem_rdata),
    .instruction (w_instruction), .if_pc (w_if_pc), .if_valid (w_if_valid),
    .if_ready (if_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits for the next rising edge, drives the inputs for the coming cycle, lets them settle.
  task automatic applyStimulus(input logic redir, input logic [63:0] rpc, input logic gnt,
                               input logic rv, input logic [31:0] rd, input logic rdy);
    @(posedge clk);
    #2;
    redirect_en = redir;
    redirect_pc = rpc;
    imem_gnt    = gnt;
    imem_rvalid = rv;
    imem_rdata  = rd;
    if_ready    = rdy;
    #2;
  endtask

  initial begin
    rst_n       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if_ready    = 1'b0;

    #12;
    $display("[TB] reset values");
    checkOutput("rst_addr",        imem_addr,   64'h0);
    checkOutput("rst_valid",       if_valid,    64'h0);
    checkOutput("rst_instr",       instruction, 64'h0);
    checkOutput("rst_if_pc",       if_pc,       64'h0);
    checkOutput("rst_wrap_addr",   w_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);

    $display("[TB] first fetch with immediate grant");
    rst_n    = 1'b1;
    imem_gnt = 1'b1;
    #2;
    checkOutput("f1_req",  imem_req,  64'h1);
    checkOutput("f1_addr", imem_addr, 64'h0);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 32'h00A00093, 1'b0);
    checkOutput("f1_wait_req",   imem_req, 64'h0);
    checkOutput("f1_wait_valid", if_valid, 64'h0);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("f1_valid",      if_valid,    64'h1);
    checkOutput("f1_instr",      instruction, 64'h00A00093);
    checkOutput("f1_if_pc",      if_pc,       64'h0);
    checkOutput("f1_wrap_if_pc", w_if_pc,     64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("f1_next_req",   imem_req,    64'h1);
    checkOutput("f1_next_addr",  imem_addr,   64'h4);
    checkOutput("f1_wrap_next",  w_imem_addr, 64'h0);

    $display("[TB] backpressure in HOLD");
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 32'h00100113, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("bp_valid", if_valid,    64'h1);
      checkOutput("bp_instr", instruction, 64'h00100113);
      checkOutput("bp_if_pc", if_pc,       64'h4);
      checkOutput("bp_req",   imem_req,    64'h0);
      checkOutput("bp_addr",  imem_addr,   64'h8);
    end
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("bp_release_valid", if_valid, 64'h1);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("bp_after_req",   imem_req,  64'h1);
    checkOutput("bp_after_addr",  imem_addr, 64'h8);
    checkOutput("bp_after_valid", if_valid,  64'h0);

    $display("[TB] redirect while waiting for a response");
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 64'h103, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("rw_req",   imem_req, 64'h0);
    checkOutput("rw_valid", if_valid, 64'h0);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
    checkOutput("rw_flush_valid", if_valid, 64'h0);
    checkOutput("rw_flush_req",   imem_req, 64'h0);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("rw_next_valid", if_valid,  64'h0);
    checkOutput("rw_next_req",   imem_req,  64'h1);
    checkOutput("rw_next_addr",  imem_addr, 64'h100);

    $display("[TB] redirect in HOLD with ready high");
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 32'h00000013, 1'b0);
    applyStimulus(1'b1, 64'h200, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("rh_valid", if_valid,    64'h0);
    checkOutput("rh_req",   imem_req,    64'h0);
    checkOutput("rh_instr", instruction, 64'h13);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("rh_next_req",   imem_req,  64'h1);
    checkOutput("rh_next_addr",  imem_addr, 64'h200);
    checkOutput("rh_next_valid", if_valid,  64'h0);

    $display("[TB] asynchronous reset while waiting");
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("ar_wait_req", imem_req, 64'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_addr",  imem_addr,   64'h0);
    checkOutput("ar_valid", if_valid,    64'h0);
    checkOutput("ar_instr", instruction, 64'h0);
    checkOutput("ar_if_pc", if_pc,       64'h0);
    #3;
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0BAD0;
    #2;
    checkOutput("ar_rel_req",  imem_req,  64'h1);
    checkOutput("ar_rel_addr", imem_addr, 64'h0);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 32'hBAD0BAD0, 1'b1);
    checkOutput("ar_stray_req",   imem_req,  64'h1);
    checkOutput("ar_stray_addr",  imem_addr, 64'h0);
    checkOutput("ar_stray_valid", if_valid,  64'h0);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("ar_idle_req",   imem_req, 64'h1);
    checkOutput("ar_idle_valid", if_valid, 64'h0);

    $display("[TB] randomized traffic");
    m_pc        = 64'h0;
    m_busy      = 1'b0;
    m_flush     = 1'b0;
    m_present   = 1'b0;
    m_instr     = '0;
    m_ipc       = '0;
    mem_pending = 1'b0;
    mem_delay   = 0;
    mem_data    = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk);
      #2;
      redirect_en = ($urandom % 10) == 0;
      redirect_pc = {$urandom, $urandom};
      if (($urandom % 4) == 0) redirect_pc[63:4] = '1;
      if_ready    = ($urandom % 3) != 0;
      if (mem_pending && mem_delay == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_data;
      end else begin
        imem_rvalid = !mem_pending && (($urandom % 6) == 0);
        imem_rdata  = $urandom;
      end
      imem_gnt = $urandom % 2;
      #2;

      exp_req   = !m_busy && !m_present && !redirect_en;
      exp_valid = m_present && !redirect_en;
      checkOutput("rnd_req",   imem_req, 64'(exp_req));
      checkOutput("rnd_valid", if_valid, 64'(exp_valid));
      if (exp_req) checkOutput("rnd_addr", imem_addr, m_pc);
      if (exp_valid) begin
        checkOutput("rnd_instr", instruction, 64'(m_instr));
        checkOutput("rnd_if_pc", if_pc,       m_ipc);
      end

      if (redirect_en) begin
        m_pc      = redirect_pc & ~64'h3;
        m_present = 1'b0;
        if (m_busy && imem_rvalid) begin
          m_busy  = 1'b0;
          m_flush = 1'b0;
        end else if (m_busy) begin
          m_flush = 1'b1;
        end
      end else if (m_present) begin
        if (if_ready) m_present = 1'b0;
      end else if (m_busy) begin
        if (imem_rvalid) begin
          m_busy = 1'b0;
          if (m_flush) begin
            m_flush = 1'b0;
          end else begin
            m_present = 1'b1;
            m_instr   = imem_rdata;
            m_ipc     = m_pc;
            m_pc      = m_pc + 64'd4;
          end
        end
      end else if (exp_req && imem_gnt) begin
        m_busy = 1'b1;
      end

      if (mem_pending && imem_rvalid) begin
        mem_pending = 1'b0;
      end else if (mem_pending && mem_delay > 0) begin
        mem_delay--;
      end
      if (imem_req && imem_gnt) begin
        mem_pending = 1'b1;
        mem_delay   = $urandom_range(0, 2);
        mem_data    = $urandom;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
